// File: rtl/scr1_mem_arbiter_pkg.sv
// rtl/scr1_mem_arbiter_pkg.sv - shared memory-interface types and arbiter FSM encoding
package scr1_mem_arbiter_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_ARB_ADDR = 1'b0,
        SCR1_ARB_DATA = 1'b1
    } type_scr1_arb_fsm_e;

endpackage

// File: rtl/scr1_arb_rr2.sv
// rtl/scr1_arb_rr2.sv - two-way grant logic with last-winner register
module scr1_arb_rr2 (
    input  logic clk,
    input  logic rst,
    input  logic rr_mode,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    output logic gnt
);

    logic last_q;
    logic last_d;

    // Grant select: contention resolved by mode, single requester always wins
    always_comb begin
        gnt = req1;
        if (req0 && req1) begin
            gnt = rr_mode ? ~last_q : 1'b0;
        end
    end

    // Remember the winner of each accepted request
    always_comb begin
        last_d = upd ? gnt : last_q;
    end

    // last resets to m1 so m0 takes the first contended grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/scr1_mem_arbiter.sv
// rtl/scr1_mem_arbiter.sv - two-master to one-slave SCR1 memory port arbiter
module scr1_mem_arbiter
    import scr1_mem_arbiter_pkg::*;
#(
    parameter bit SCR1_ARB_RR = 1'b1,
    parameter int SCR1_AWIDTH = SCR1_DMEM_AWIDTH,
    parameter int SCR1_DWIDTH = SCR1_DMEM_DWIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req,
    output logic                   m0_req_ack,
    input  type_scr1_mem_cmd_e     m0_cmd,
    input  logic [SCR1_AWIDTH-1:0] m0_addr,
    input  logic [SCR1_DWIDTH-1:0] m0_wdata,
    output logic [SCR1_DWIDTH-1:0] m0_rdata,
    output type_scr1_mem_resp_e    m0_resp,
    input  logic                   m1_req,
    output logic                   m1_req_ack,
    input  type_scr1_mem_cmd_e     m1_cmd,
    input  logic [SCR1_AWIDTH-1:0] m1_addr,
    input  logic [SCR1_DWIDTH-1:0] m1_wdata,
    output logic [SCR1_DWIDTH-1:0] m1_rdata,
    output type_scr1_mem_resp_e    m1_resp,
    output logic                   s_req,
    input  logic                   s_req_ack,
    output type_scr1_mem_cmd_e     s_cmd,
    output logic [SCR1_AWIDTH-1:0] s_addr,
    output logic [SCR1_DWIDTH-1:0] s_wdata,
    input  logic [SCR1_DWIDTH-1:0] s_rdata,
    input  type_scr1_mem_resp_e    s_resp
);

    type_scr1_arb_fsm_e state_q;
    type_scr1_arb_fsm_e state_d;
    logic               own_q;
    logic               own_d;
    logic               win;
    logic               any_req;
    logic               accept;
    logic               gnt;

    // A new request may be taken when idle or as the current one completes OK
    assign win     = (state_q == SCR1_ARB_ADDR) ||
                     ((state_q == SCR1_ARB_DATA) && (s_resp == SCR1_MEM_RESP_RDY_OK));
    assign any_req = m0_req | m1_req;
    assign accept  = s_req & s_req_ack;

    scr1_arb_rr2 i_arb (
        .clk     (clk),
        .rst     (rst),
        .rr_mode (SCR1_ARB_RR),
        .req0    (m0_req),
        .req1    (m1_req),
        .upd     (accept),
        .gnt     (gnt)
    );

    // State and owner registers; reset drops any outstanding transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCR1_ARB_ADDR;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
        end
    end

    // Next state: acceptance wins, otherwise any final response returns to idle
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        if (accept) begin
            state_d = SCR1_ARB_DATA;
            own_d   = gnt;
        end else if ((state_q == SCR1_ARB_DATA) && (s_resp != SCR1_MEM_RESP_NOTRDY)) begin
            state_d = SCR1_ARB_ADDR;
        end
    end

    // Outputs: forward granted request, route response to the current owner
    always_comb begin
        s_req      = win & any_req & ~rst;
        s_cmd      = SCR1_MEM_CMD_ERROR;
        if (any_req) begin
            s_cmd = gnt ? m1_cmd : m0_cmd;
        end
        s_addr     = gnt ? m1_addr  : m0_addr;
        s_wdata    = gnt ? m1_wdata : m0_wdata;
        m0_req_ack = s_req & s_req_ack & ~gnt & m0_req;
        m1_req_ack = s_req & s_req_ack &  gnt & m1_req;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        m0_resp    = SCR1_MEM_RESP_NOTRDY;
        m1_resp    = SCR1_MEM_RESP_NOTRDY;
        if (state_q == SCR1_ARB_DATA) begin
            if (own_q) begin
                m1_resp = s_resp;
            end else begin
                m0_resp = s_resp;
            end
        end
    end

`ifdef SCR1_SIM_ENV
    a_no_x_req : assert property (@(posedge clk) disable iff (rst) !$isunknown(s_req));
    a_no_x_cmd : assert property (@(posedge clk) disable iff (rst) s_req |-> !$isunknown(s_cmd));
    a_one_ack  : assert property (@(posedge clk) disable iff (rst) !(m0_req_ack && m1_req_ack));
    a_m0_resp  : assert property (@(posedge clk) disable iff (rst)
                     (m0_resp != SCR1_MEM_RESP_NOTRDY) |-> (state_q == SCR1_ARB_DATA && !own_q));
    a_m1_resp  : assert property (@(posedge clk) disable iff (rst)
                     (m1_resp != SCR1_MEM_RESP_NOTRDY) |-> (state_q == SCR1_ARB_DATA && own_q));
`endif

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// tb/tb_scr1_mem_arbiter.sv - directed bench for scr1_mem_arbiter in both arbitration modes
module tb_scr1_mem_arbiter;
    import scr1_mem_arbiter_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                m0_req, m1_req, s_req_ack;
    type_scr1_mem_cmd_e  m0_cmd, m1_cmd;
    logic [31:0]         m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    type_scr1_mem_resp_e s_resp;

    logic                rr_m0_ack, rr_m1_ack, rr_s_req;
    logic [31:0]         rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
    type_scr1_mem_resp_e rr_m0_resp, rr_m1_resp;
    type_scr1_mem_cmd_e  rr_s_cmd;

    logic                fx_m0_ack, fx_m1_ack, fx_s_req;
    logic [31:0]         fx_m0_rdata, fx_m1_rdata, fx_s_addr, fx_s_wdata;
    type_scr1_mem_resp_e fx_m0_resp, fx_m1_resp;
    type_scr1_mem_cmd_e  fx_s_cmd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    scr1_mem_arbiter #(.SCR1_ARB_RR(1'b1), .SCR1_AWIDTH(32), .SCR1_DWIDTH(32)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_req_ack(rr_m0_ack), .m0_cmd(m0_cmd), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(rr_m0_rdata), .m0_resp(rr_m0_resp),
        .m1_req(m1_req), .m1_req_ack(rr_m1_ack), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(rr_m1_rdata), .m1_resp(rr_m1_resp),
        .s_req(rr_s_req), .s_req_ack(s_req_ack), .s_cmd(rr_s_cmd), .s_addr(rr_s_addr),
        .s_wdata(rr_s_wdata), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    scr1_mem_arbiter #(.SCR1_ARB_RR(1'b0), .SCR1_AWIDTH(32), .SCR1_DWIDTH(32)) dut_fx (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_req_ack(fx_m0_ack), .m0_cmd(m0_cmd), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(fx_m0_rdata), .m0_resp(fx_m0_resp),
        .m1_req(m1_req), .m1_req_ack(fx_m1_ack), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(fx_m1_rdata), .m1_resp(fx_m1_resp),
        .s_req(fx_s_req), .s_req_ack(s_req_ack), .s_cmd(fx_s_cmd), .s_addr(fx_s_addr),
        .s_wdata(fx_s_wdata), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_RD;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        s_req_ack = 1'b0; s_resp = SCR1_MEM_RESP_NOTRDY; s_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; s_req_ack = 1'b1; s_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_chk++; if (rr_s_req !== 1'b0) $display("FAIL reset_s_req got %0b exp 0", rr_s_req); else n_pass++;
        n_chk++; if (rr_m0_ack !== 1'b0) $display("FAIL reset_m0_ack got %0b exp 0", rr_m0_ack); else n_pass++;
        n_chk++; if (rr_m1_ack !== 1'b0) $display("FAIL reset_m1_ack got %0b exp 0", rr_m1_ack); else n_pass++;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL reset_m0_resp got %0d exp 0", rr_m0_resp); else n_pass++;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL reset_m1_resp got %0d exp 0", rr_m1_resp); else n_pass++;
        n_chk++; if (fx_s_req !== 1'b0) $display("FAIL reset_fx_s_req got %0b exp 0", fx_s_req); else n_pass++;
        @(negedge clk); idle(); rst = 1'b0;
    endtask

    task automatic test_single_m0();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_cmd = SCR1_MEM_CMD_RD; m0_addr = 32'h100; s_req_ack = 1'b1;
        #1;
        n_chk++; if (rr_s_req !== 1'b1) $display("FAIL single_s_req got %0b exp 1", rr_s_req); else n_pass++;
        n_chk++; if (rr_s_addr !== 32'h100) $display("FAIL single_s_addr got %0h exp 100", rr_s_addr); else n_pass++;
        n_chk++; if (rr_s_cmd !== SCR1_MEM_CMD_RD) $display("FAIL single_s_cmd got %0d exp 0", rr_s_cmd); else n_pass++;
        n_chk++; if (rr_m0_ack !== 1'b1) $display("FAIL single_m0_ack got %0b exp 1", rr_m0_ack); else n_pass++;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL single_m1_resp0 got %0d exp 0", rr_m1_resp); else n_pass++;
        @(negedge clk);
        m0_req = 1'b0; s_req_ack = 1'b0; s_resp = SCR1_MEM_RESP_RDY_OK; s_rdata = 32'hDEADBEEF;
        #1;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_RDY_OK) $display("FAIL single_m0_resp got %0d exp 1", rr_m0_resp); else n_pass++;
        n_chk++; if (rr_m0_rdata !== 32'hDEADBEEF) $display("FAIL single_m0_rdata got %0h exp deadbeef", rr_m0_rdata); else n_pass++;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL single_m1_resp1 got %0d exp 0", rr_m1_resp); else n_pass++;
        @(negedge clk); idle();
        #1;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL single_m0_idle got %0d exp 0", rr_m0_resp); else n_pass++;
    endtask

    task automatic test_rr_contention();
        int done = 0;
        logic e0, e1;
        type_scr1_mem_resp_e r0, r1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_req = (i < 4); m1_req = (i < 4); m0_addr = 32'h10; m1_addr = 32'h20;
            s_req_ack = 1'b1;
            s_resp = (i == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
            #1;
            e0 = (i < 4) && (i % 2 == 0);
            e1 = (i < 4) && (i % 2 == 1);
            r0 = (i > 0 && (i - 1) % 2 == 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
            r1 = (i > 0 && (i - 1) % 2 == 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
            n_chk++; if (rr_m0_ack !== e0) $display("FAIL rr_m0_ack c%0d got %0b exp %0b", i, rr_m0_ack, e0); else n_pass++;
            n_chk++; if (rr_m1_ack !== e1) $display("FAIL rr_m1_ack c%0d got %0b exp %0b", i, rr_m1_ack, e1); else n_pass++;
            n_chk++; if (rr_m0_resp !== r0) $display("FAIL rr_m0_resp c%0d got %0d exp %0d", i, rr_m0_resp, r0); else n_pass++;
            n_chk++; if (rr_m1_resp !== r1) $display("FAIL rr_m1_resp c%0d got %0d exp %0d", i, rr_m1_resp, r1); else n_pass++;
            if (i < 4) begin
                n_chk++; if (rr_s_addr !== (e1 ? 32'h20 : 32'h10)) $display("FAIL rr_s_addr c%0d got %0h", i, rr_s_addr); else n_pass++;
            end
            if (rr_m0_resp == SCR1_MEM_RESP_RDY_OK || rr_m1_resp == SCR1_MEM_RESP_RDY_OK) done++;
        end
        n_chk++; if (done !== 4) $display("FAIL rr_done got %0d exp 4", done); else n_pass++;
        @(negedge clk); idle();
    endtask

    task automatic test_fixed_contention();
        int acks = 0;
        type_scr1_mem_resp_e r0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m0_req = (i < 4); m1_req = (i < 4); m0_addr = 32'h30; m1_addr = 32'h40;
            s_req_ack = 1'b1;
            s_resp = (i == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
            #1;
            r0 = (i > 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
            n_chk++; if (fx_m0_ack !== (i < 4)) $display("FAIL fx_m0_ack c%0d got %0b exp %0b", i, fx_m0_ack, (i < 4)); else n_pass++;
            n_chk++; if (fx_m1_ack !== 1'b0) $display("FAIL fx_m1_ack c%0d got %0b exp 0", i, fx_m1_ack); else n_pass++;
            n_chk++; if (fx_m0_resp !== r0) $display("FAIL fx_m0_resp c%0d got %0d exp %0d", i, fx_m0_resp, r0); else n_pass++;
            n_chk++; if (fx_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL fx_m1_resp c%0d got %0d exp 0", i, fx_m1_resp); else n_pass++;
            if (fx_m0_ack) acks++;
        end
        n_chk++; if (acks !== 4) $display("FAIL fx_acks got %0d exp 4", acks); else n_pass++;
        @(negedge clk); idle();
    endtask

    task automatic test_error();
        do_reset();
        @(negedge clk);
        m1_req = 1'b1; m1_cmd = SCR1_MEM_CMD_WR; m1_addr = 32'h200; m1_wdata = 32'h55AA; s_req_ack = 1'b1;
        #1;
        n_chk++; if (rr_m1_ack !== 1'b1) $display("FAIL err_m1_ack got %0b exp 1", rr_m1_ack); else n_pass++;
        n_chk++; if (rr_s_cmd !== SCR1_MEM_CMD_WR) $display("FAIL err_s_cmd got %0d exp 1", rr_s_cmd); else n_pass++;
        n_chk++; if (rr_s_wdata !== 32'h55AA) $display("FAIL err_s_wdata got %0h exp 55aa", rr_s_wdata); else n_pass++;
        @(negedge clk);
        m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h300; s_resp = SCR1_MEM_RESP_RDY_ER;
        #1;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_RDY_ER) $display("FAIL err_m1_resp got %0d exp 2", rr_m1_resp); else n_pass++;
        n_chk++; if (rr_m0_ack !== 1'b0) $display("FAIL err_m0_ack got %0b exp 0", rr_m0_ack); else n_pass++;
        n_chk++; if (rr_s_req !== 1'b0) $display("FAIL err_s_req got %0b exp 0", rr_s_req); else n_pass++;
        @(negedge clk);
        s_resp = SCR1_MEM_RESP_NOTRDY;
        #1;
        n_chk++; if (rr_m0_ack !== 1'b1) $display("FAIL err_m0_next_ack got %0b exp 1", rr_m0_ack); else n_pass++;
        n_chk++; if (rr_s_addr !== 32'h300) $display("FAIL err_s_addr got %0h exp 300", rr_s_addr); else n_pass++;
        @(negedge clk);
        m0_req = 1'b0; s_req_ack = 1'b0; s_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_RDY_OK) $display("FAIL err_m0_resp got %0d exp 1", rr_m0_resp); else n_pass++;
        @(negedge clk); idle();
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        m1_req = 1'b1; m1_addr = 32'h40; s_req_ack = 1'b1;
        #1;
        n_chk++; if (rr_m1_ack !== 1'b1) $display("FAIL stall_m1_ack got %0b exp 1", rr_m1_ack); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h44; s_resp = SCR1_MEM_RESP_NOTRDY;
            #1;
            n_chk++; if (rr_s_req !== 1'b0) $display("FAIL stall_s_req c%0d got %0b exp 0", i, rr_s_req); else n_pass++;
            n_chk++; if (rr_m0_ack !== 1'b0) $display("FAIL stall_m0_ack c%0d got %0b exp 0", i, rr_m0_ack); else n_pass++;
            n_chk++; if (rr_m1_ack !== 1'b0) $display("FAIL stall_m1_ack c%0d got %0b exp 0", i, rr_m1_ack); else n_pass++;
            n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL stall_m1_resp c%0d got %0d exp 0", i, rr_m1_resp); else n_pass++;
        end
        @(negedge clk);
        s_resp = SCR1_MEM_RESP_RDY_OK; s_rdata = 32'h1234;
        #1;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_RDY_OK) $display("FAIL stall_m1_ok got %0d exp 1", rr_m1_resp); else n_pass++;
        n_chk++; if (rr_m1_rdata !== 32'h1234) $display("FAIL stall_m1_rdata got %0h exp 1234", rr_m1_rdata); else n_pass++;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL stall_m0_resp got %0d exp 0", rr_m0_resp); else n_pass++;
        n_chk++; if (rr_m0_ack !== 1'b1) $display("FAIL stall_pipe_m0_ack got %0b exp 1", rr_m0_ack); else n_pass++;
        @(negedge clk);
        m0_req = 1'b0; s_req_ack = 1'b0;
        #1;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_RDY_OK) $display("FAIL stall_m0_ok got %0d exp 1", rr_m0_resp); else n_pass++;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL stall_m1_after got %0d exp 0", rr_m1_resp); else n_pass++;
        @(negedge clk); idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h80; s_req_ack = 1'b1;
        #1;
        n_chk++; if (rr_m0_ack !== 1'b1) $display("FAIL rmid_m0_ack got %0b exp 1", rr_m0_ack); else n_pass++;
        @(negedge clk);
        rst = 1'b1; m1_req = 1'b1; s_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_chk++; if (rr_s_req !== 1'b0) $display("FAIL rmid_s_req got %0b exp 0", rr_s_req); else n_pass++;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL rmid_m0_resp got %0d exp 0", rr_m0_resp); else n_pass++;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL rmid_m1_resp got %0d exp 0", rr_m1_resp); else n_pass++;
        n_chk++; if ((rr_m0_ack | rr_m1_ack) !== 1'b0) $display("FAIL rmid_acks got %0b%0b exp 00", rr_m0_ack, rr_m1_ack); else n_pass++;
        @(negedge clk);
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; s_req_ack = 1'b0; s_resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_chk++; if (rr_m0_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL rmid_late_m0 got %0d exp 0", rr_m0_resp); else n_pass++;
        n_chk++; if (rr_m1_resp !== SCR1_MEM_RESP_NOTRDY) $display("FAIL rmid_late_m1 got %0d exp 0", rr_m1_resp); else n_pass++;
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h90; s_req_ack = 1'b1; s_resp = SCR1_MEM_RESP_NOTRDY;
        #1;
        n_chk++; if (rr_m0_ack !== 1'b1) $display("FAIL rmid_next_m0 got %0b exp 1", rr_m0_ack); else n_pass++;
        n_chk++; if (rr_m1_ack !== 1'b0) $display("FAIL rmid_next_m1 got %0b exp 0", rr_m1_ack); else n_pass++;
        @(negedge clk); idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_m0();
        test_rr_contention();
        test_fixed_contention();
        test_error();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scr1_mem_arbiter.md
# scr1_mem_arbiter

Two-master to one-slave arbiter for the SCR1 memory interface (req/req_ack/cmd/addr/wdata/rdata/resp). It lets two initiators share a single memory port, for example the core IMEM path and a debug/DMA fetcher sharing one TCM or AHB bridge port. It allows one outstanding transaction at a time. Arbitration is fixed-priority or round-robin, and a new request is accepted in the same cycle the current response completes, so back-to-back throughput matches the single-master case.

## Interface
- `SCR1_ARB_RR`, default 1: 1 selects round-robin; 0 selects fixed priority with m0 winning.
- `SCR1_AWIDTH`, default `` `SCR1_DMEM_AWIDTH ``: address width.
- `SCR1_DWIDTH`, default `` `SCR1_DMEM_DWIDTH ``: data width.
- `clk  in  1`: clock. The block is single-clock.
- `rst  in  1`: reset, asynchronous and active-high.
- `m0_req  in  1`: master 0 request.
- `m0_req_ack  out  1`: request accepted this cycle.
- `m0_cmd  in  type_scr1_mem_cmd_e`: RD/WR.
- `m0_addr  in  AWIDTH`: address.
- `m0_wdata  in  DWIDTH`: write data.
- `m0_rdata  out  DWIDTH`: read data.
- `m0_resp  out  type_scr1_mem_resp_e`: response.
- `m1_*`: same set of ports as m0, for master 1.
- `s_req  out  1`: request to the slave.
- `s_req_ack  in  1`: slave accepts the request.
- `s_cmd  out  type_scr1_mem_cmd_e`: forwarded command.
- `s_addr  out  AWIDTH`: forwarded address.
- `s_wdata  out  DWIDTH`: forwarded write data.
- `s_rdata  in  DWIDTH`: slave read data.
- `s_resp  in  type_scr1_mem_resp_e`: slave response.

## Operation
- FSM has two states.
  - ADDR: no transaction outstanding.
  - DATA: one transaction outstanding. The owner register `own` (0/1) records which master issued it.
- Arbitration window ("win"): state ADDR, or state DATA with `s_resp == RDY_OK`.
- Grant `gnt` is combinational and only valid in win.
  - Fixed mode: m0 is granted if `m0_req`, otherwise m1.
  - RR mode: if both masters request, grant goes to the master that is not `last`. Otherwise grant goes to whichever is requesting.
- Slave-side outputs:
  - `s_req = win & (m0_req | m1_req) & ~rst`.
  - `s_cmd`, `s_addr` and `s_wdata` are muxed from `gnt`.
  - When no master requests, `s_cmd = SCR1_MEM_CMD_ERROR`.
- Master acknowledge: `mX_req_ack = win & (gnt==X) & mX_req & s_req_ack`. The non-granted master always sees ack=0.
- Acceptance: when `s_req & s_req_ack`, the next state is DATA, `own <= gnt`, and `last <= gnt`.
- Leaving DATA:
  - On `RDY_OK` with no new acceptance, go to ADDR.
  - On `RDY_ER`, go to ADDR. No new grant is given in that cycle, because win excludes RDY_ER.
  - On `NOTRDY`, hold.
- Response routing:
  - In DATA, `m[own]_resp = s_resp` and `m[own]_rdata = s_rdata`.
  - The other master gets `resp = SCR1_MEM_RESP_NOTRDY`.
  - In ADDR, both masters get NOTRDY.
  - `rdata` for a non-owner is don't-care; drive it with `s_rdata`.
- Request holding: masters hold req/cmd/addr/wdata stable until acked. The arbiter may re-arbitrate on every cycle without ack, so a grant is not sticky before ack.

## Timing
- Reset values: FSM=ADDR, `own=0`, `last=1`, so m0 wins the first contended cycle in RR mode.
- Outputs while `rst` is asserted: `s_req=0`, all `req_ack=0`, both `resp=NOTRDY`.
- Reset asserted mid-transaction: the state is dropped immediately. A slave response arriving after reset deasserts is ignored, because FSM is in ADDR.
- Latency: zero cycles combinational from master to slave, and zero cycles from slave response to the master. Registered state adds no bubbles.
- Pipelining: a response with `RDY_OK` and a new acceptance can occur in the same cycle, possibly for the other master.
  - Resp routing uses the old `own`.
  - The new `own` takes effect on the next cycle.
- Simultaneous requests in RR mode strictly alternate, giving a starvation bound of 1 transaction.
- Fixed mode has no starvation guarantee for m1.

## Structure
- Reuse `type_scr1_mem_cmd_e` / `type_scr1_mem_resp_e` from `scr1_memif.svh`.
- Add the local FSM enum `type_scr1_arb_fsm_e` {SCR1_ARB_ADDR, SCR1_ARB_DATA} to the same header for reuse.
- One natural sub-module is `scr1_arb_rr2`: the 2-way grant logic plus the `last` register, with a mode input.
- The FSM and muxing stay in the top module.
- SVA under `SCR1_SIM_ENV`:
  - No X on `s_req`/`s_cmd` while `s_req` is asserted.
  - Never more than one `req_ack` asserted per cycle.
  - `mX_resp != NOTRDY` only when `own == X`.

## Test plan
- **Single master, m0:** m0 issues RD 0x100 and the slave acks immediately. The slave responds RDY_OK with rdata 0xDEADBEEF one cycle later. Required: m0_resp=RDY_OK, m0_rdata=0xDEADBEEF, m1_resp=NOTRDY throughout.
- **Contention, RR mode:** both masters request continuously, with a slave that acks every request and responds RDY_OK in the next cycle. Required: grants alternate m0, m1, m0, m1, and 4 transactions complete in 5 cycles.
- **Contention, fixed mode (`SCR1_ARB_RR=0`):** both masters request for 4 accepted transactions. Required: all 4 go to m0, and m1_req_ack stays 0.
- **Error response:** m1 WR 0x200 receives RDY_ER while m0_req is pending in the same cycle. Required: m1_resp=RDY_ER, m0_req_ack=0 in that cycle, m0 granted in the next cycle.
- **Slave stall:** the slave holds NOTRDY for 3 cycles. Required: FSM stays DATA, `s_req=0`, both acks 0; then RDY_OK is delivered only to the owner.
- **Reset mid-transaction:** `rst` is pulsed while in DATA. Required: `s_req=0` and both resp=NOTRDY during reset. A late RDY_OK after reset is not forwarded, and the next contended grant goes to m0.
